video_wr_sched: RTL and testbench

Write scheduler and arbiter in front of the video system's 21-bit FPro write port.
- Queues CPU writes in a FIFO.
- Releases frame-buffer writes immediately and holds video-slot register writes until a blanking window opens, so sprite, OSD and bar registers never change mid-frame.
- Shares the port with one hardware requester (e.g. a note-scroller engine) that only writes slot registers.
- Sits between the CPU bus and `video_sys_daisy` (its `video_*` outputs drive that block's `video_*` inputs).

---
 rtl/video_wr_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_video_wr_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_sched.sv
// Write scheduler/arbiter for the 21-bit FPro video write port: queues CPU writes and defers slot-register writes to the blanking window.
// Define VIDEO_SCHED_RR_EN for round-robin FIFO/hardware arbitration; default is fixed priority (FIFO first).
module video_wr_sched #(
  parameter int FIFO_AW    = 4,
  parameter int WIN_CYCLES = 16384
) (
  input  logic        clk_sys,
  input  logic        reset_sys_n,
  input  logic        cpu_cs,
  input  logic        cpu_wr,
  input  logic [20:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic        hw_valid,
  output logic        hw_ready,
  input  logic [20:0] hw_addr,
  input  logic [31:0] hw_wr_data,
  input  logic        frame_end,
  input  logic        win_force,
  input  logic        ovf_clr,
  output logic        video_cs,
  output logic        video_wr,
  output logic [20:0] video_addr,
  output logic [31:0] video_wr_data,
  output logic        win_open,
  output logic        fifo_empty,
  output logic        ovf_sticky
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(WIN_CYCLES - 1);
  localparam logic [FIFO_AW:0]   FIFO_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {
    WIN_CLOSED = 1'b0,
    WIN_OPEN   = 1'b1
  } win_state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [52:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic        cpu_we;
  logic        full;
  logic        push;
  logic        pop;
  logic [20:0] head_addr;
  logic [31:0] head_data;

  assign cpu_we     = cpu_cs & cpu_wr;
  assign full       = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = cpu_we & ~full;
  assign {head_addr, head_data} = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cpu_addr, cpu_wr_data};
    end
  end

  // NOTE: every variable in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop never rescues the write.
    if (cpu_we & full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!reset_sys_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf_sticky = ovf_q;

  // ---------------------------------------------------------------------------
  // Update-window controller
  // ---------------------------------------------------------------------------
  win_state_e       win_state_q, win_state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_sys_n) begin
      win_state_q <= WIN_CLOSED;
      win_cnt_q   <= '0;
    end else begin
      win_state_q <= win_state_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  always_comb begin
    win_state_d = win_state_q;
    win_cnt_d   = win_cnt_q;
    case (win_state_q)
      WIN_CLOSED: begin
        if (frame_end) begin
          win_state_d = WIN_OPEN;
          win_cnt_d   = CNT_LOAD;
        end
      end
      WIN_OPEN: begin
        if (frame_end) begin
          win_cnt_d = CNT_LOAD;
        end else if (win_cnt_q == '0) begin
          win_state_d = WIN_CLOSED;
        end else begin
          win_cnt_d = win_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        win_state_d = WIN_CLOSED;
        win_cnt_d   = '0;
      end
    endcase
  end

  assign win_open = (win_state_q == WIN_OPEN) | win_force;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  logic head_elig;
  logic hw_elig;
  logic fifo_gnt;
  logic hw_gnt;

  // A blocked slot-write head stalls everything behind it to keep strict ordering.
  assign head_elig = ~fifo_empty & (head_addr[20] | win_open);
  assign hw_elig   = hw_valid & win_open;

`ifdef VIDEO_SCHED_RR_EN
  logic last_hw_q, last_hw_d;

  always_comb begin
    fifo_gnt  = head_elig & (~hw_elig | last_hw_q);
    hw_gnt    = hw_elig & ~fifo_gnt;
    last_hw_d = last_hw_q;
    if (fifo_gnt) begin
      last_hw_d = 1'b0;
    end else if (hw_gnt) begin
      last_hw_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_sys_n) begin
      last_hw_q <= 1'b1;
    end else begin
      last_hw_q <= last_hw_d;
    end
  end
`else
  always_comb begin
    fifo_gnt = head_elig;
    hw_gnt   = hw_elig & ~head_elig;
  end
`endif

  assign pop      = fifo_gnt;
  assign hw_ready = hw_gnt;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        vid_cs_q, vid_cs_d;
  logic [20:0] vid_addr_q, vid_addr_d;
  logic [31:0] vid_data_q, vid_data_d;

  always_comb begin
    vid_cs_d   = fifo_gnt | hw_gnt;
    vid_addr_d = vid_addr_q;
    vid_data_d = vid_data_q;
    if (fifo_gnt) begin
      vid_addr_d = head_addr;
      vid_data_d = head_data;
    end else if (hw_gnt) begin
      vid_addr_d = hw_addr;
      vid_data_d = hw_wr_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_sys_n) begin
      vid_cs_q   <= 1'b0;
      vid_addr_q <= '0;
      vid_data_q <= '0;
    end else begin
      vid_cs_q   <= vid_cs_d;
      vid_addr_q <= vid_addr_d;
      vid_data_q <= vid_data_d;
    end
  end

  assign video_cs      = vid_cs_q;
  assign video_wr      = vid_cs_q;
  assign video_addr    = vid_addr_q;
  assign video_wr_data = vid_data_q;

endmodule

// File: tb/tb_video_wr_sched.sv
// Directed bench for video_wr_sched (WIN_CYCLES = 8, 16-entry FIFO).
// Expected arbitration order follows VIDEO_SCHED_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_video_wr_sched;

  logic        clk_sys = 1'b0;
  logic        reset_sys_n;
  logic        cpu_cs;
  logic        cpu_wr;
  logic [20:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic        hw_valid;
  logic        hw_ready;
  logic [20:0] hw_addr;
  logic [31:0] hw_wr_data;
  logic        frame_end;
  logic        win_force;
  logic        ovf_clr;
  logic        video_cs;
  logic        video_wr;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;
  logic        win_open;
  logic        fifo_empty;
  logic        ovf_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  video_wr_sched #(.FIFO_AW(4), .WIN_CYCLES(8)) dut (
    .clk_sys      (clk_sys),
    .reset_sys_n  (reset_sys_n),
    .cpu_cs       (cpu_cs),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_wr_data  (cpu_wr_data),
    .hw_valid     (hw_valid),
    .hw_ready     (hw_ready),
    .hw_addr      (hw_addr),
    .hw_wr_data   (hw_wr_data),
    .frame_end    (frame_end),
    .win_force    (win_force),
    .ovf_clr      (ovf_clr),
    .video_cs     (video_cs),
    .video_wr     (video_wr),
    .video_addr   (video_addr),
    .video_wr_data(video_wr_data),
    .win_open     (win_open),
    .fifo_empty   (fifo_empty),
    .ovf_sticky   (ovf_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_write(input logic [20:0] a, input logic [31:0] d);
    cpu_cs      = 1'b1;
    cpu_wr      = 1'b1;
    cpu_addr    = a;
    cpu_wr_data = d;
    step();
    cpu_cs = 1'b0;
    cpu_wr = 1'b0;
  endtask

  logic [20:0] exp5 [8];
  int          cnt_a;
  int          cnt_b;
  int          first_cs;
  int          last_cs;

  initial begin
`ifdef VIDEO_SCHED_RR_EN
    exp5 = '{21'h000200, 21'h00C300, 21'h000201, 21'h00C300,
             21'h000202, 21'h00C300, 21'h000203, 21'h00C300};
`else
    exp5 = '{21'h000200, 21'h000201, 21'h000202, 21'h000203,
             21'h00C300, 21'h00C300, 21'h00C300, 21'h00C300};
`endif
    reset_sys_n = 1'b0;
    cpu_cs      = 1'b0;
    cpu_wr      = 1'b0;
    cpu_addr    = '0;
    cpu_wr_data = '0;
    hw_valid    = 1'b1;
    hw_addr     = 21'h00C000;
    hw_wr_data  = 32'h0;
    frame_end   = 1'b0;
    win_force   = 1'b0;
    ovf_clr     = 1'b0;

    // Reset state
    step_n(2);
    check("rst_cs", 32'(video_cs), 32'h0);
    check("rst_wr", 32'(video_wr), 32'h0);
    check("rst_addr", 32'(video_addr), 32'h0);
    check("rst_data", video_wr_data, 32'h0);
    check("rst_win", 32'(win_open), 32'h0);
    check("rst_hw_ready", 32'(hw_ready), 32'h0);
    check("rst_ovf", 32'(ovf_sticky), 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'h1);
    hw_valid    = 1'b0;
    reset_sys_n = 1'b1;
    step();

    // 1: frame-buffer write passes through a closed window, 2-cycle latency
    cpu_write(21'h100000, 32'hABC);
    check("t1_cs_n1", 32'(video_cs), 32'h0);
    check("t1_queued", 32'(fifo_empty), 32'h0);
    step();
    check("t1_cs", 32'(video_cs), 32'h1);
    check("t1_wr", 32'(video_wr), 32'h1);
    check("t1_addr", 32'(video_addr), 32'h100000);
    check("t1_data", video_wr_data, 32'hABC);
    check("t1_win", 32'(win_open), 32'h0);
    step();
    check("t1_cs_pulse", 32'(video_cs), 32'h0);
    check("t1_addr_hold", 32'(video_addr), 32'h100000);
    check("t1_empty", 32'(fifo_empty), 32'h1);

    // 2: slot-write head blocks the frame-buffer write behind it
    cpu_write(21'h00C004, 32'h5);
    cpu_write(21'h100010, 32'h77);
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      if (video_cs) cnt_a++;
      step();
    end
    check("t2_blocked", 32'(cnt_a), 32'h0);
    check("t2_pending", 32'(fifo_empty), 32'h0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("t2_win_open", 32'(win_open), 32'h1);
    step();
    check("t2_cs0", 32'(video_cs), 32'h1);
    check("t2_addr0", 32'(video_addr), 32'h00C004);
    check("t2_data0", video_wr_data, 32'h5);
    step();
    check("t2_cs1", 32'(video_cs), 32'h1);
    check("t2_addr1", 32'(video_addr), 32'h100010);
    check("t2_data1", video_wr_data, 32'h77);
    step();
    check("t2_idle", 32'(video_cs), 32'h0);
    step_n(4);
    check("t2_win_last", 32'(win_open), 32'h1);
    step();
    check("t2_win_closed", 32'(win_open), 32'h0);

    // 3: overflow, sticky clear, set-wins-over-clear, drain of exactly 16
    for (int i = 0; i < 17; i++) begin
      cpu_cs      = 1'b1;
      cpu_wr      = 1'b1;
      cpu_addr    = 21'(32'h100 + i);
      cpu_wr_data = 32'(i);
      if (i == 16) check("t3_ovf_before", 32'(ovf_sticky), 32'h0);
      step();
    end
    cpu_cs = 1'b0;
    cpu_wr = 1'b0;
    check("t3_ovf_set", 32'(ovf_sticky), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf_sticky), 32'h0);
    cpu_cs      = 1'b1;
    cpu_wr      = 1'b1;
    cpu_addr    = 21'h0001FF;
    cpu_wr_data = 32'hFFFF;
    ovf_clr     = 1'b1;
    step();
    cpu_cs  = 1'b0;
    cpu_wr  = 1'b0;
    ovf_clr = 1'b0;
    check("t3_set_wins", 32'(ovf_sticky), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    win_force = 1'b1;
    #1;
    check("t3_force_win", 32'(win_open), 32'h1);
    cnt_a    = 0;
    first_cs = -1;
    last_cs  = -1;
    for (int c = 0; c < 24; c++) begin
      if (video_cs) begin
        check("t3_drain_addr", 32'(video_addr), 32'h100 + 32'(cnt_a));
        check("t3_drain_data", video_wr_data, 32'(cnt_a));
        if (first_cs < 0) first_cs = c;
        last_cs = c;
        cnt_a++;
      end
      step();
    end
    win_force = 1'b0;
    check("t3_drain_count", 32'(cnt_a), 32'd16);
    check("t3_back_to_back", 32'(last_cs - first_cs), 32'd15);
    check("t3_empty", 32'(fifo_empty), 32'h1);
    check("t3_ovf_cleared", 32'(ovf_sticky), 32'h0);

    // 4: hardware requester gets exactly WIN_CYCLES transfers
    hw_addr    = 21'h00C100;
    hw_wr_data = 32'h1234;
    hw_valid   = 1'b1;
    #1;
    check("t4_closed_ready", 32'(hw_ready), 32'h0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) check("t4_latency", 32'(video_cs), 32'h1);
      if (hw_ready) cnt_a++;
      if (video_cs) cnt_b++;
      step();
    end
    check("t4_ready_count", 32'(cnt_a), 32'd8);
    check("t4_cs_count", 32'(cnt_b), 32'd8);
    check("t4_ready_low", 32'(hw_ready), 32'h0);
    check("t4_addr", 32'(video_addr), 32'h00C100);
    check("t4_data", video_wr_data, 32'h1234);
    hw_valid = 1'b0;

    // 4b: frame_end while open reloads the counter
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step_n(3);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step_n(7);
    check("t4b_reload_open", 32'(win_open), 32'h1);
    step();
    check("t4b_reload_closed", 32'(win_open), 32'h0);

    // 5: FIFO vs hardware arbitration from a fresh reset (last = hw)
    reset_sys_n = 1'b0;
    step();
    reset_sys_n = 1'b1;
    for (int i = 0; i < 4; i++) cpu_write(21'(32'h200 + i), 32'h10 + 32'(i));
    hw_addr    = 21'h00C300;
    hw_wr_data = 32'hDEAD;
    hw_valid   = 1'b1;
    frame_end  = 1'b1;
    step();
    frame_end = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 10; c++) begin
      if (video_cs) begin
        if (cnt_a < 8) check("t5_order", 32'(video_addr), 32'(exp5[cnt_a]));
        cnt_a++;
      end
      step();
    end
    hw_valid = 1'b0;
    check("t5_grants", 32'(cnt_a), 32'd8);
    check("t5_empty", 32'(fifo_empty), 32'h1);

    // 6: reset mid-operation discards queue and pending grant
    for (int i = 0; i < 3; i++) cpu_write(21'(32'h300 + i), 32'h20 + 32'(i));
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("t6_pre_open", 32'(win_open), 32'h1);
    check("t6_pre_queued", 32'(fifo_empty), 32'h0);
    reset_sys_n = 1'b0;
    step();
    check("t6_cs", 32'(video_cs), 32'h0);
    check("t6_empty", 32'(fifo_empty), 32'h1);
    check("t6_win", 32'(win_open), 32'h0);
    check("t6_addr", 32'(video_addr), 32'h0);
    reset_sys_n = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 6; c++) begin
      if (video_cs) cnt_a++;
      step();
    end
    check("t6_silent", 32'(cnt_a), 32'h0);
    cpu_write(21'h100020, 32'h99);
    step();
    check("t6_new_cs", 32'(video_cs), 32'h1);
    check("t6_new_addr", 32'(video_addr), 32'h100020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
